layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised successor to the fixed 3-screen menu mux: composites N_LAYERS overlay layers over the
//  background stream, per a game-state visibility map, with a 2-cycle registered pipeline.
//  Applies state changes only at frame boundaries and fades in after each switch.
//  Sits between draw_bg/draw_* producers and the VGA pins; game_fsm drives state_req.
// PARAMETERS
//  N_LAYERS        4        number of overlay layers; higher index = higher priority (drawn on top)
//  N_STATES        4        number of game states; SW = $clog2(N_STATES)
//  RGB_W           12       pixel width, 3 equal channels of RGB_W/3 bits (4 each)
//  STATE_MAP       'hF      N_STATES*N_LAYERS bits; bit [s*N_LAYERS+l] = layer l visible in state s
//  RESET_STATE     0        state_cur after reset
//  FADE_EN         1        1: fade-in after switch; 0: switch instantly at full level
//  FRAMES_PER_STEP 2        frames per fade level step (>=1)
// PORTS
//  clk          in   1               pixel clock
//  rst_n        in   1               asynchronous, active-low reset
//  state_req    in   SW              requested game state (from game_fsm)
//  rgb_bg       in   RGB_W           background pixel
//  layer_rgb    in   N_LAYERS*RGB_W  layer pixels, layer l at [l*RGB_W +: RGB_W]
//  layer_valid  in   N_LAYERS        layer l pixel opaque this cycle
//  hsync_in     in   1               horizontal sync aligned with rgb inputs
//  vsync_in     in   1               vertical sync (active-high), aligned with rgb inputs
//  blank_in     in   1               hblnk|vblnk aligned with rgb inputs
//  hsync_out    out  1               hsync_in delayed 2 cycles
//  vsync_out    out  1               vsync_in delayed 2 cycles
//  rgb_out      out  RGB_W           composited, faded pixel; 0 while blanked
//  state_cur    out  SW              state currently displayed
//  fade_busy    out  1               1 while fade level < 15
// BEHAVIOUR
//  - Reset (async, rst_n=0): all pipeline regs, hsync_out, vsync_out, rgb_out = 0; state_cur=RESET_STATE;
//    level=15; frame counter=0; fade_busy=0; vsync_q=0.
//  - Frame edge fe = vsync_in & ~vsync_q (vsync_q = vsync_in registered).
//  - On fe: if state_req<N_STATES and state_req!=state_cur -> state_cur<=state_req; level<=(FADE_EN?0:15);
//    frame counter<=0. Out-of-range state_req ignored. state_req between edges ignored.
//  - Else on fe with level<15: counter++; when counter==FRAMES_PER_STEP-1 -> counter<=0, level++.
//  - New request during fade: accepted at next fe, restarts at level 0 (request beats step, same edge).
//  - fade_busy = (level!=15), registered with level. level only changes on fe (inside vblank; no tearing).
//  - Stage 1 (cycle 1): sel = highest l with layer_valid[l] & STATE_MAP[state_cur*N_LAYERS+l];
//    none -> rgb_bg. Register pixel, hsync, vsync, blank.
//  - Stage 2 (cycle 2): each channel c: c_out = (c*(level+1))>>4 (8-bit product, truncate to 4 bits);
//    level 15 -> exact passthrough, level 0 -> 0. blank -> rgb_out=0. Syncs registered again.
//  - Latency input->output exactly 2 clk for pixel, hsync, vsync; state_cur updates 1 clk after fe.
// STRUCTURE
//  - vga_pkg: RGB_W, CH_W=RGB_W/3, FADE_MAX=15, fade level typedef logic [3:0].
//  - Sub-module rgb_fader (stage 2: per-channel scale + blank + sync delay), instantiated once.
//  - Layer priority select: for-loop priority encoder in stage 1, no sub-module.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> all outputs 0 immediately; release -> state_cur=0, fade_busy=0.
//  2 Priority: state 0 map 'hF, layer_valid=4'b0110, layer1=12'h0F0, layer2=12'hF00 -> rgb_out=12'hF00
//    after 2 clk; valid=0 -> rgb_bg; map bit cleared for layer2 -> 12'h0F0.
//  3 Switch: state_req 0->2 mid-frame -> state_cur stays 0 until fe, =2 one clk after;
//    next frame pixel 12'hFFF outputs 12'h000 (level 0), fade_busy=1.
//  4 Fade ramp, FRAMES_PER_STEP=2: 12'hFFF -> level +1 every 2 frames; after 30 frames rgb_out=12'hFFF,
//    fade_busy=0; level 7 gives 12'h777.
//  5 Restart/edge cases: new state_req at level 9 -> level 0 on next fe; state_req=N_STATES ignored;
//    FADE_EN=0 -> switch shows full level, fade_busy never 1.
//  6 Timing: hsync/vsync/blank toggles emerge exactly 2 clk later; blank_in=1 -> rgb_out=0 at any level.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared pixel, fade-level and channel definitions
// for the VGA output path.
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int CH_W  = RGB_W / 3;

  typedef logic [3:0] fade_t;

  localparam fade_t FADE_MAX = 4'd15;

endpackage

// File: rtl/rgb_fader.sv
// Output stage: per-channel brightness scale,
// blank forcing and second sync delay.
module rgb_fader
  import vga_pkg::*;
#(
  parameter int RGB_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] i_rgb,
  input  logic             i_blank,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  fade_t            i_level,
  output logic [RGB_W-1:0] o_rgb,
  output logic             o_hsync,
  output logic             o_vsync
);

  localparam int CW = RGB_W / 3;
  localparam int PW = CW + 4;

  logic [4:0]       w_mul;
  logic [PW-1:0]    w_prod [3];
  logic [RGB_W-1:0] w_rgb;

  assign w_mul = {1'b0, i_level} + 5'd1;

  // Scale each channel by (level+1)/16;
  // level 15 is an exact passthrough.
  always_comb begin
    w_rgb = '0;
    for (int c = 0; c < 3; c++) begin
      w_prod[c] = PW'(i_rgb[c*CW +: CW])
                * PW'(w_mul);
      w_rgb[c*CW +: CW] = w_prod[c][PW-1:4];
    end
  end

  // Register scaled pixel (zero in blank)
  // together with the syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rgb   <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      o_rgb   <= i_blank ? '0 : w_rgb;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Overlay compositor: state-gated layer priority,
// frame-synchronous state switch and fade-in.
module layer_compositor
  import vga_pkg::*;
#(
  parameter int N_LAYERS        = 4,
  parameter int N_STATES        = 4,
  parameter int RGB_W           = vga_pkg::RGB_W,
  parameter logic [N_STATES*N_LAYERS-1:0]
                STATE_MAP       = 'hF,
  parameter int RESET_STATE     = 0,
  parameter bit FADE_EN         = 1'b1,
  parameter int FRAMES_PER_STEP = 2,
  localparam int SW = (N_STATES > 1) ?
                      $clog2(N_STATES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SW-1:0]             state_req,
  input  logic [RGB_W-1:0]          rgb_bg,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_valid,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [RGB_W-1:0]          rgb_out,
  output logic [SW-1:0]             state_cur,
  output logic                      fade_busy
);

  localparam int CNTW = (FRAMES_PER_STEP > 1) ?
                        $clog2(FRAMES_PER_STEP) : 1;

  logic [SW-1:0]       r_state;
  fade_t               r_level;
  logic [CNTW-1:0]     r_cnt;
  logic                r_busy;
  logic                r_vsync_q;

  logic [RGB_W-1:0]    r_pix;
  logic                r_hs;
  logic                r_vs;
  logic                r_blank;

  logic                w_fe;
  logic                w_req_ok;
  logic [N_LAYERS-1:0] w_vis;
  logic [RGB_W-1:0]    w_pix;

  assign w_fe     = vsync_in & ~r_vsync_q;
  assign w_req_ok = ({1'b0, state_req} <
                     (SW+1)'(N_STATES)) &&
                    (state_req != r_state);

  assign state_cur = r_state;
  assign fade_busy = r_busy;

  // Visibility mask of the displayed state.
  always_comb begin
    w_vis = '0;
    for (int s = 0; s < N_STATES; s++) begin
      if (r_state == SW'(s))
        w_vis = STATE_MAP[s*N_LAYERS +: N_LAYERS];
    end
  end

  // Priority select: highest visible opaque
  // layer wins, else background.
  always_comb begin
    w_pix = rgb_bg;
    for (int l = 0; l < N_LAYERS; l++) begin
      if (layer_valid[l] & w_vis[l])
        w_pix = layer_rgb[l*RGB_W +: RGB_W];
    end
  end

  // State switch and fade stepping, only on
  // the rising edge of vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SW'(RESET_STATE);
      r_level   <= FADE_MAX;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= vsync_in;
      if (w_fe) begin
        if (w_req_ok) begin
          r_state <= state_req;
          r_level <= FADE_EN ? '0 : FADE_MAX;
          r_busy  <= FADE_EN;
          r_cnt   <= '0;
        end else if (r_level != FADE_MAX) begin
          if (r_cnt ==
              CNTW'(FRAMES_PER_STEP - 1)) begin
            r_cnt   <= '0;
            r_level <= r_level + 4'd1;
            r_busy  <= (r_level != 4'd14);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  // First pipeline stage: selected pixel
  // and timing signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix   <= '0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_pix   <= w_pix;
      r_hs    <= hsync_in;
      r_vs    <= vsync_in;
      r_blank <= blank_in;
    end
  end

  rgb_fader #(
    .RGB_W (RGB_W)
  ) u_fader (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_rgb   (r_pix),
    .i_blank (r_blank),
    .i_hsync (r_hs),
    .i_vsync (r_vs),
    .i_level (r_level),
    .o_rgb   (rgb_out),
    .o_hsync (hsync_out),
    .o_vsync (vsync_out)
  );

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench: dut0 uses defaults, dut1 has
// 3 states, map 'h0FB and no fade.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  state_req;
  logic [11:0] rgb_bg;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_valid;
  logic        hsync_in, vsync_in, blank_in;

  logic        hs0, vs0, busy0;
  logic [11:0] rgb0;
  logic [1:0]  st0;
  logic        hs1, vs1, busy1;
  logic [11:0] rgb1;
  logic [1:0]  st1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  layer_compositor dut0 (
    .clk (clk), .rst_n (rst_n),
    .state_req (state_req), .rgb_bg (rgb_bg),
    .layer_rgb (layer_rgb),
    .layer_valid (layer_valid),
    .hsync_in (hsync_in), .vsync_in (vsync_in),
    .blank_in (blank_in),
    .hsync_out (hs0), .vsync_out (vs0),
    .rgb_out (rgb0), .state_cur (st0),
    .fade_busy (busy0)
  );

  layer_compositor #(
    .N_STATES (3),
    .STATE_MAP (12'h0FB),
    .FADE_EN (1'b0)
  ) dut1 (
    .clk (clk), .rst_n (rst_n),
    .state_req (state_req), .rgb_bg (rgb_bg),
    .layer_rgb (layer_rgb),
    .layer_valid (layer_valid),
    .hsync_in (hsync_in), .vsync_in (vsync_in),
    .blank_in (blank_in),
    .hsync_out (hs1), .vsync_out (vs1),
    .rgb_out (rgb1), .state_cur (st1),
    .fade_busy (busy1)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] bg;
    logic        blank;
    logic [11:0] exp0;
    logic [11:0] exp1;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame;
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    tbl[0] = '{4'b0110, 12'hABC, 1'b0,
               12'hF00, 12'h0F0};
    tbl[1] = '{4'b0000, 12'hABC, 1'b0,
               12'hABC, 12'hABC};
    tbl[2] = '{4'b0001, 12'h555, 1'b0,
               12'h00F, 12'h00F};
    tbl[3] = '{4'b1111, 12'hABC, 1'b0,
               12'h123, 12'h123};
    tbl[4] = '{4'b0100, 12'h3C7, 1'b0,
               12'hF00, 12'h3C7};
    tbl[5] = '{4'b0110, 12'hABC, 1'b1,
               12'h000, 12'h000};
    tbl[6] = '{4'b1000, 12'hABC, 1'b0,
               12'h123, 12'h123};

    rst_n       = 1'b0;
    state_req   = 2'd0;
    rgb_bg      = '0;
    layer_rgb   = {12'h123, 12'hF00,
                   12'h0F0, 12'h00F};
    layer_valid = '0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    blank_in    = 1'b0;

    #3;
    chk("reset_rgb", rgb0, 12'h000);
    chk("reset_state", {10'd0, st0}, 12'h000);
    chk("reset_busy", {11'd0, busy0}, 12'h000);
    chk("reset_hsync", {11'd0, hs0}, 12'h000);
    #7 rst_n = 1'b1;
    tick();

    // Priority / map table at full level.
    for (int i = 0; i < 7; i++) begin
      layer_valid = tbl[i].valid;
      rgb_bg      = tbl[i].bg;
      blank_in    = tbl[i].blank;
      tick(); tick();
      chk($sformatf("vec%0d_dut0", i),
          rgb0, tbl[i].exp0);
      chk($sformatf("vec%0d_dut1", i),
          rgb1, tbl[i].exp1);
    end
    blank_in    = 1'b0;
    layer_valid = '0;

    // Sync latency: exactly two clocks.
    hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    chk("hs_lat1", {11'd0, hs0}, 12'h000);
    tick();
    chk("hs_lat2", {11'd0, hs0}, 12'h001);
    tick();
    chk("hs_lat3", {11'd0, hs0}, 12'h000);
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    chk("vs_lat1", {11'd0, vs1}, 12'h000);
    tick();
    chk("vs_lat2", {11'd0, vs1}, 12'h001);
    tick();
    chk("vs_lat3", {11'd0, vs1}, 12'h000);
    chk("no_switch", {10'd0, st0}, 12'h000);

    // Mid-frame request waits for frame edge.
    rgb_bg    = 12'hFFF;
    state_req = 2'd2;
    tick(); tick();
    chk("sw_hold", {10'd0, st0}, 12'h000);
    vsync_in = 1'b1;
    chk("sw_pre_edge", {10'd0, st0}, 12'h000);
    tick();
    vsync_in = 1'b0;
    chk("sw_state0", {10'd0, st0}, 12'h002);
    chk("sw_state1", {10'd0, st1}, 12'h002);
    chk("sw_busy0", {11'd0, busy0}, 12'h001);
    chk("sw_busy1", {11'd0, busy1}, 12'h000);
    tick(); tick();
    chk("sw_lvl0", rgb0, 12'h000);
    chk("sw_nofade", rgb1, 12'hFFF);

    // Ramp: one level per two frames.
    for (int f = 0; f < 14; f++) frame();
    chk("lvl7", rgb0, 12'h777);
    chk("lvl7_busy", {11'd0, busy0}, 12'h001);
    blank_in = 1'b1;
    tick(); tick();
    chk("blank_lvl7", rgb0, 12'h000);
    chk("blank_full", rgb1, 12'h000);
    blank_in = 1'b0;
    tick(); tick();
    for (int f = 0; f < 4; f++) frame();
    chk("lvl9", rgb0, 12'h999);

    // Restart from level 9.
    state_req = 2'd1;
    frame();
    chk("rs_state", {10'd0, st0}, 12'h001);
    chk("rs_lvl0", rgb0, 12'h000);
    chk("rs_busy", {11'd0, busy0}, 12'h001);
    chk("rs_dut1", rgb1, 12'hFFF);
    for (int f = 0; f < 29; f++) frame();
    chk("lvl14", rgb0, 12'hEEE);
    chk("lvl14_busy", {11'd0, busy0}, 12'h001);
    frame();
    chk("lvl15", rgb0, 12'hFFF);
    chk("lvl15_busy", {11'd0, busy0}, 12'h000);
    chk("never_busy1", {11'd0, busy1}, 12'h000);

    // State 3 is out of range for dut1 only.
    state_req = 2'd3;
    frame();
    chk("oor_dut1", {10'd0, st1}, 12'h001);
    chk("oor_dut0", {10'd0, st0}, 12'h003);
    chk("oor_busy0", {11'd0, busy0}, 12'h001);

    // Asynchronous reset mid-frame.
    hsync_in = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_hs", {11'd0, hs1}, 12'h001);
    chk("pre_rst_rgb", rgb1, 12'hFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", rgb1, 12'h000);
    chk("arst_hs", {11'd0, hs1}, 12'h000);
    chk("arst_st0", {10'd0, st0}, 12'h000);
    chk("arst_st1", {10'd0, st1}, 12'h000);
    chk("arst_busy0", {11'd0, busy0}, 12'h000);
    state_req = 2'd0;
    #1 rst_n = 1'b1;
    tick();
    chk("rel_st0", {10'd0, st0}, 12'h000);
    chk("rel_busy0", {11'd0, busy0}, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
